// File: rtl/load_align.sv
// Memory-stage load aligner: lane-shifts read words, size-masks them and merges split loads.
// Optional sign extension of byte/doubleword results is compiled in with `define LOAD_SEXT_EN.
module load_align (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        flush,
  input  logic        valid_in,
  input  logic        is_load,
  input  logic [4:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic        second_half,
  input  logic        sext,
  input  logic [4:0]  tgt_in,
  input  logic [31:0] rdata,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [4:0]  tgt_out,
  output logic        busy,
  output logic        proto_err
);

  typedef enum logic [1:0] {SZ_NONE, SZ_W, SZ_D, SZ_B} size_e;
  typedef enum logic {IDLE, WAIT_HI} state_e;

`ifdef LOAD_SEXT_EN
  localparam bit SEXT_EN = 1'b1;
`else
  localparam bit SEXT_EN = 1'b0;
`endif

  state_e      state;
  logic [31:0] lo_hold;
  logic [1:0]  nlo;
  size_e       size_q;
  logic [4:0]  tgt_q;
  logic        sext_q;

  size_e       sz;
  logic        is_split;
  logic        first_acc;
  logic        second_acc;
  logic [31:0] shifted;
  logic [31:0] merged;

  function automatic logic [31:0] size_mask(input logic [31:0] d, input size_e s, input logic sx);
    logic fill;
    logic [31:0] r;
    r = d;
    case (s)
      SZ_D: begin
        fill = SEXT_EN & sx & d[15];
        r    = {{16{fill}}, d[15:0]};
      end
      SZ_B: begin
        fill = SEXT_EN & sx & d[7];
        r    = {{24{fill}}, d[7:0]};
      end
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    sz = SZ_NONE;
    case (opcode)
      5'd3, 5'd4, 5'd5:  sz = SZ_W;
      5'd6, 5'd7, 5'd8:  sz = SZ_D;
      5'd9, 5'd10, 5'd11: sz = SZ_B;
      default:           sz = SZ_NONE;
    endcase
  end

  always_comb begin
    is_split   = ((sz == SZ_W) && (addr_lo != 2'd0)) || ((sz == SZ_D) && (addr_lo == 2'd3));
    first_acc  = valid_in && is_load && !second_half && (sz != SZ_NONE);
    second_acc = valid_in && is_load && second_half;
    shifted    = rdata >> {addr_lo, 3'b000};
    merged     = lo_hold | (rdata << {nlo, 3'b000});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      result       <= '0;
      result_valid <= 1'b0;
      tgt_out      <= '0;
      busy         <= 1'b0;
      proto_err    <= 1'b0;
      lo_hold      <= '0;
      nlo          <= '0;
      size_q       <= SZ_NONE;
      tgt_q        <= '0;
      sext_q       <= 1'b0;
    end else if (!halt) begin
      result_valid <= 1'b0;
      tgt_out      <= '0;
      proto_err    <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (state == WAIT_HI && second_acc) begin
        result       <= size_mask(merged, size_q, sext_q);
        result_valid <= 1'b1;
        tgt_out      <= tgt_q;
        state        <= IDLE;
        busy         <= 1'b0;
      end else if (state == IDLE && second_acc) begin
        proto_err <= 1'b1;
      end else if (first_acc) begin
        // A first half arriving in WAIT_HI drops the held half and is then handled as from IDLE.
        proto_err <= (state == WAIT_HI);
        if (is_split) begin
          lo_hold <= shifted;
          nlo     <= 2'd0 - addr_lo;
          size_q  <= sz;
          tgt_q   <= tgt_in;
          sext_q  <= sext;
          state   <= WAIT_HI;
          busy    <= 1'b1;
        end else begin
          result       <= size_mask(shifted, sz, sext);
          result_valid <= 1'b1;
          tgt_out      <= tgt_in;
          state        <= IDLE;
          busy         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_align.sv
// Directed self-checking bench for load_align with a result/target scoreboard queue.
module tb_load_align;

  logic        clk = 1'b0;
  logic        rst, halt, flush, valid_in, is_load, second_half, sext;
  logic [4:0]  opcode, tgt_in;
  logic [1:0]  addr_lo;
  logic [31:0] rdata;
  logic [31:0] result;
  logic        result_valid, busy, proto_err;
  logic [4:0]  tgt_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] sb[$];

  load_align dut (
    .clk(clk), .rst(rst), .halt(halt), .flush(flush), .valid_in(valid_in),
    .is_load(is_load), .opcode(opcode), .addr_lo(addr_lo), .second_half(second_half),
    .sext(sext), .tgt_in(tgt_in), .rdata(rdata), .result(result),
    .result_valid(result_valid), .tgt_out(tgt_out), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [1:0] off, input logic sh,
                       input logic sx, input logic [4:0] tgt, input logic [31:0] rd);
    valid_in = 1'b1; is_load = 1'b1; opcode = op; addr_lo = off;
    second_half = sh; sext = sx; tgt_in = tgt; rdata = rd;
  endtask

  task automatic bubble();
    valid_in = 1'b0; is_load = 1'b0; opcode = '0; addr_lo = '0;
    second_half = 1'b0; sext = 1'b0; tgt_in = '0; rdata = '0;
  endtask

  task automatic expect_res(input logic [31:0] r, input logic [4:0] t);
    sb.push_back({r, t});
  endtask

  // One clock; outputs sampled 1ns after the edge and matched against the scoreboard.
  task automatic tick();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("valid", {31'b0, result_valid}, 32'd1);
      chk("result", result, e[36:5]);
      chk("tgt", {27'b0, tgt_out}, {27'b0, e[4:0]});
    end else begin
      chk("novalid", {31'b0, result_valid}, 32'd0);
      chk("tgt_zero", {27'b0, tgt_out}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] exp_b, exp_d;
    rst = 1'b1; halt = 1'b0; flush = 1'b0;
    bubble();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_valid", {31'b0, result_valid}, 32'd0);
    chk("rst_tgt", {27'b0, tgt_out}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_perr", {31'b0, proto_err}, 32'd0);
    rst = 1'b0;

    // aligned word
    drive(5'd3, 2'd0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF); expect_res(32'hDEADBEEF, 5'd5); tick();
    chk("lw_busy", {31'b0, busy}, 32'd0);

    // byte loads
`ifdef LOAD_SEXT_EN
    exp_b = 32'hFFFFFFA2;
`else
    exp_b = 32'h000000A2;
`endif
    drive(5'd9, 2'd2, 1'b0, 1'b1, 5'd7, 32'h11A23344); expect_res(exp_b, 5'd7); tick();
    drive(5'd10, 2'd2, 1'b0, 1'b0, 5'd8, 32'h11A23344); expect_res(32'h000000A2, 5'd8); tick();
    drive(5'd7, 2'd1, 1'b0, 1'b0, 5'd6, 32'h00ABCD00); expect_res(32'h0000ABCD, 5'd6); tick();

    // split word, off=1
    drive(5'd4, 2'd1, 1'b0, 1'b0, 5'd9, 32'hAABBCCDD); tick();
    chk("split_busy", {31'b0, busy}, 32'd1);
    drive(5'd3, 2'd0, 1'b1, 1'b0, 5'd1, 32'h11223344); expect_res(32'h44AABBCC, 5'd9); tick();
    chk("split_done_busy", {31'b0, busy}, 32'd0);

    // split doubleword, off=3, with a bubble
`ifdef LOAD_SEXT_EN
    exp_d = 32'hFFFFFF80;
`else
    exp_d = 32'h0000FF80;
`endif
    drive(5'd6, 2'd3, 1'b0, 1'b1, 5'd12, 32'h80000000); tick();
    bubble(); tick();
    chk("ld_bubble_busy", {31'b0, busy}, 32'd1);
    drive(5'd6, 2'd0, 1'b1, 1'b0, 5'd0, 32'h000000FF); expect_res(exp_d, 5'd12); tick();

    // second half in IDLE
    drive(5'd3, 2'd0, 1'b1, 1'b0, 5'd2, 32'h12121212); tick();
    chk("idle_sh_perr", {31'b0, proto_err}, 32'd1);
    bubble(); tick();
    chk("perr_pulse", {31'b0, proto_err}, 32'd0);

    // flush during WAIT_HI beats the second half
    drive(5'd3, 2'd2, 1'b0, 1'b0, 5'd10, 32'h01020304); tick();
    drive(5'd3, 2'd0, 1'b1, 1'b0, 5'd10, 32'h05060708); flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_perr", {31'b0, proto_err}, 32'd0);
    drive(5'd5, 2'd0, 1'b0, 1'b0, 5'd3, 32'h12345678); expect_res(32'h12345678, 5'd3); tick();

    // new first half while waiting: held half dropped, new one served
    drive(5'd3, 2'd2, 1'b0, 1'b0, 5'd11, 32'h99887766); tick();
    drive(5'd3, 2'd0, 1'b0, 1'b0, 5'd4, 32'hCAFEF00D); expect_res(32'hCAFEF00D, 5'd4); tick();
    chk("restart_perr", {31'b0, proto_err}, 32'd1);
    chk("restart_busy", {31'b0, busy}, 32'd0);

    // halt freezes WAIT_HI for 3 cycles
    drive(5'd3, 2'd3, 1'b0, 1'b0, 5'd20, 32'h55667788); tick();
    drive(5'd3, 2'd0, 1'b1, 1'b0, 5'd0, 32'h00AABBCC); halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_busy", {31'b0, busy}, 32'd1);
    end
    halt = 1'b0;
    expect_res(32'hAABBCC55, 5'd20); tick();

    // async reset mid-split
    drive(5'd3, 2'd1, 1'b0, 1'b0, 5'd2, 32'hABCDEF01); tick();
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    bubble();
    #2 rst = 1'b1;
    #1;
    chk("async_busy", {31'b0, busy}, 32'd0);
    chk("async_result", result, 32'd0);
    chk("async_valid", {31'b0, result_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(5'd3, 2'd0, 1'b1, 1'b0, 5'd2, 32'h11111111); tick();
    chk("post_rst_perr", {31'b0, proto_err}, 32'd1);
    bubble(); tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
